// File: rtl/updown_pkg.sv
// ---------------------------------------------------------------------------
// updown_pkg
// Shared definitions for the up/down counter Wishbone controller:
//   - register indices (word offset, adr[4:2])
//   - CTRL register bit positions
//   - bus handshake and sequencer state encodings
//   - byte-lane merge helper used by every writable register
// ---------------------------------------------------------------------------
package updown_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_LIMIT    = 3'd2;
  localparam logic [2:0] REG_LOAD     = 3'd3;
  localparam logic [2:0] REG_COUNT    = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_UP      = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_IRQ_EN  = 3;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

  typedef enum logic {
    SEQ_STOP,
    SEQ_RUN
  } seq_state_e;

  // Replace only the byte lanes selected by sel; other lanes keep old data.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// updown_wb_ctrl_if
// Wishbone-classic slave bundle between the management SoC and the counter
// controller. Signal names follow the user-project wrapper so the wiring in
// user_proj_example stays one-to-one.
//   master : drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave  : the reverse
// ---------------------------------------------------------------------------
interface updown_wb_ctrl_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/updown_prescaler.sv
// ---------------------------------------------------------------------------
// updown_prescaler
// Free-running divider for the counter step rate. Counts 0..presc while en
// is high and flags the terminal cycle on wrap; wraps back to 0 afterwards.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count enable (sequencer running)
//   clr        : force count to 0 on the next edge (priority over en)
//   presc      : terminal count, one wrap every presc+1 enabled cycles
//   wrap       : combinational, high in the cycle where count == presc
// ---------------------------------------------------------------------------
module updown_prescaler #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               wrap
);

  logic [PRESC_W-1:0] cnt;

  assign wrap = en && (cnt == presc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_wb_ctrl.sv
// ---------------------------------------------------------------------------
// updown_wb_ctrl
// Wishbone-classic slave that configures and sequences the up/down counter.
// Holds CTRL / PRESCALE / LIMIT / LOAD, reads back the counter value, emits
// step / direction / load strobes and raises a level interrupt when a
// one-shot count reaches its terminal value.
//   wb_clk_i, wb_rst_ni : clock, synchronous active-low reset
//   wb                  : Wishbone slave bundle (updown_wb_ctrl_if.slave)
//   cnt_val_i           : current counter value
//   cnt_step_o          : one-cycle step strobe
//   cnt_up_o            : direction, 1 = increment
//   cnt_load_o          : one-cycle load strobe
//   cnt_load_val_o      : value to load, held until the next load
//   irq_o               : done & irq_en, registered (user_irq[0])
// ---------------------------------------------------------------------------
module updown_wb_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned PRESC_W   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  updown_wb_ctrl_if.slave  wb,
  input  logic [WIDTH-1:0] cnt_val_i,
  output logic             cnt_step_o,
  output logic             cnt_up_o,
  output logic             cnt_load_o,
  output logic [WIDTH-1:0] cnt_load_val_o,
  output logic             irq_o
);

  bus_state_e bus_state, bus_next;
  seq_state_e seq_state, seq_next;

  logic [3:0]         ctrl;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0]   limit;
  logic [WIDTH-1:0]   load_val;
  logic               done;
  logic               load_q;
  logic               irq_q;
  logic [31:0]        rdat_q;
  logic [31:0]        rdata;

  logic       hit, accept, wr;
  logic [2:0] reg_idx;
  logic       wr_ctrl, wr_presc, wr_limit, wr_load, wr_status;
  logic       load_fire, w1c_done, run_set, run_clr;
  logic       wrap, at_term, step_slot, terminal;
  logic       unused_adr;

  // adr[1:0] are byte offsets inside a word; lanes are selected by sel.
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  // ---- bus decode --------------------------------------------------------
  assign hit     = wb.wbs_cyc_i && wb.wbs_stb_i &&
                   (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  // A strobe held through the ACK cycle is not sampled again.
  assign accept  = (bus_state == BUS_IDLE) && hit;
  assign wr      = accept && wb.wbs_we_i;
  assign reg_idx = wb.wbs_adr_i[4:2];

  assign wr_ctrl   = wr && (reg_idx == REG_CTRL);
  assign wr_presc  = wr && (reg_idx == REG_PRESCALE);
  assign wr_limit  = wr && (reg_idx == REG_LIMIT);
  assign wr_load   = wr && (reg_idx == REG_LOAD);
  assign wr_status = wr && (reg_idx == REG_STATUS);

  assign load_fire = wr_load && (|wb.wbs_sel_i);
  assign w1c_done  = wr_status && wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
  assign run_set   = wr_ctrl && wb.wbs_sel_i[0] && wb.wbs_dat_i[CTRL_RUN];
  assign run_clr   = wr_ctrl && wb.wbs_sel_i[0] && !wb.wbs_dat_i[CTRL_RUN];

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_CTRL:     rdata = 32'(ctrl);
      REG_PRESCALE: rdata = 32'(prescale);
      REG_LIMIT:    rdata = 32'(limit);
      REG_COUNT:    rdata = 32'(cnt_val_i);
      REG_STATUS:   rdata = {31'd0, done};
      default:      rdata = '0;
    endcase
  end

  // ---- bus handshake FSM -------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) bus_state <= BUS_IDLE;
    else            bus_state <= bus_next;
  end

  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      BUS_IDLE: if (hit) bus_next = BUS_ACK;
      BUS_ACK:  bus_next = BUS_IDLE;
      default:  bus_next = BUS_IDLE;
    endcase
  end

  // Read data is captured on the accepting edge and zeroed outside ACK.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni)                  rdat_q <= '0;
    else if (accept && !wb.wbs_we_i) rdat_q <= rdata;
    else                             rdat_q <= '0;
  end

  assign wb.wbs_ack_o = (bus_state == BUS_ACK);
  assign wb.wbs_dat_o = rdat_q;

  // ---- sequencer ---------------------------------------------------------
  updown_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .en    (seq_state == SEQ_RUN),
    .clr   ((seq_state == SEQ_STOP) || load_q),
    .presc (prescale),
    .wrap  (wrap)
  );

  assign at_term = ctrl[CTRL_UP] ? (cnt_val_i == limit) : (cnt_val_i == '0);

  // A wrap is a would-be step unless a load strobe or a run-clear write
  // claims the cycle.
  assign step_slot  = wrap && !load_q && !run_clr;
  assign terminal   = step_slot && ctrl[CTRL_ONESHOT] && at_term;
  assign cnt_step_o = step_slot && !terminal;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) seq_state <= SEQ_STOP;
    else            seq_state <= seq_next;
  end

  always_comb begin
    seq_next = seq_state;
    case (seq_state)
      SEQ_STOP: if (run_set) seq_next = SEQ_RUN;
      SEQ_RUN:  if (run_clr || terminal) seq_next = SEQ_STOP;
      default:  seq_next = SEQ_STOP;
    endcase
  end

  // ---- register file -----------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ctrl     <= '0;
      prescale <= '0;
      limit    <= '0;
      load_val <= '0;
      done     <= 1'b0;
      load_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      load_q <= load_fire;
      irq_q  <= done && ctrl[CTRL_IRQ_EN];
      if (wr_ctrl)
        ctrl <= 4'(byte_merge(32'(ctrl), wb.wbs_dat_i, wb.wbs_sel_i));
      // Terminal event overrides a coincident CTRL write of the run bit.
      if (terminal)
        ctrl[CTRL_RUN] <= 1'b0;
      if (wr_presc)
        prescale <= PRESC_W'(byte_merge(32'(prescale), wb.wbs_dat_i, wb.wbs_sel_i));
      if (wr_limit)
        limit <= WIDTH'(byte_merge(32'(limit), wb.wbs_dat_i, wb.wbs_sel_i));
      if (wr_load)
        load_val <= WIDTH'(byte_merge(32'(load_val), wb.wbs_dat_i, wb.wbs_sel_i));
      // Set wins over write-1-to-clear and over a load's clear.
      if (terminal)                  done <= 1'b1;
      else if (w1c_done || load_fire) done <= 1'b0;
    end
  end

  assign cnt_up_o       = ctrl[CTRL_UP];
  assign cnt_load_o     = load_q;
  assign cnt_load_val_o = load_val;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_updown_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_wb_ctrl
// Bench for updown_wb_ctrl: drives Wishbone accesses through the interface,
// models the counter core fed by the step/load strobes, and compares every
// ack's read data against a queue of expected values.
// ---------------------------------------------------------------------------
module tb_updown_wb_ctrl;

  localparam int          WIDTH = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  updown_wb_ctrl_if wb ();

  logic [WIDTH-1:0] cnt_val, mcnt, force_val, load_val;
  logic             force_en, step, up, load, irq;

  assign cnt_val = force_en ? force_val : mcnt;

  updown_wb_ctrl #(
    .WIDTH     (WIDTH),
    .PRESC_W   (16),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .wb             (wb),
    .cnt_val_i      (cnt_val),
    .cnt_step_o     (step),
    .cnt_up_o       (up),
    .cnt_load_o     (load),
    .cnt_load_val_o (load_val),
    .irq_o          (irq)
  );

  // Counter core: updates on the edge that ends a strobe cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)    mcnt <= '0;
    else if (load) mcnt <= load_val;
    else if (step) mcnt <= up ? mcnt + 1'b1 : mcnt - 1'b1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   step_log[$];
  int   load_log[$];
  logic step_at_load = 1'b0;
  int   cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Scoreboard and strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (wb.wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        chk("unexp_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk(e.tag, wb.wbs_dat_o, e.val);
      end
    end
    if (step) step_log.push_back(cyc_n);
    if (load) begin
      load_log.push_back(cyc_n);
      step_at_load = step;
    end
  end

  task automatic bus_idle();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
  endtask

  task automatic bus(input string tag, input bit we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input logic [31:0] rexp, input bit acked);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    if (acked) begin
      e.tag = tag;
      e.val = we ? 32'h0 : rexp;
      exp_q.push_back(e);
    end
    do begin
      @(negedge clk);
      n++;
    end while (!wb.wbs_ack_o && n < 8);
    if (acked) chk({tag, "_lat"}, n, 2);
    else       chk({tag, "_noack"}, {31'd0, wb.wbs_ack_o}, 0);
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic wr(input string tag, input logic [4:0] off, input logic [31:0] dat,
                    input logic [3:0] sel);
    bus(tag, 1'b1, BASE | 32'(off), dat, sel, 32'h0, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [4:0] off, input logic [31:0] exp);
    bus(tag, 1'b0, BASE | 32'(off), 32'h0, 4'hF, exp, 1'b1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int L, prev, nxt, n;
    bus_idle();
    force_en  = 1'b0;
    force_val = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {28'd0, wb.wbs_ack_o, step, load, irq}, 0);
    chk("rst_dat", wb.wbs_dat_o, 0);
    chk("rst_lval", 32'(load_val), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // COUNT readback
    force_en  = 1'b1;
    force_val = 16'h00A5;
    rd("count", 5'h10, 32'h0000_00A5);
    force_en  = 1'b0;

    // Free-run up, one step every 4 cycles
    wr("w_presc", 5'h04, 32'd3, 4'hF);
    wr("w_ctrl", 5'h00, 32'h3, 4'hF);
    step_log.delete();
    wait_cyc(20);
    chk("fr_up", {31'd0, up}, 1);
    chk("fr_nsteps", {31'd0, step_log.size() >= 4}, 1);
    if (step_log.size() >= 4)
      for (int i = 1; i < 4; i++) chk("fr_gap", step_log[i] - step_log[i-1], 4);
    rd("r_ctrl", 5'h00, 32'h3);
    rd("r_presc", 5'h04, 32'h3);
    wr("w_stop", 5'h00, 32'h0, 4'hF);
    wait_cyc(2);
    step_log.delete();
    wait_cyc(12);
    chk("stopped", step_log.size(), 0);

    // One-shot down from 5
    wr("w_presc0", 5'h04, 32'd0, 4'hF);
    wr("w_load5", 5'h0C, 32'd5, 4'hF);
    wait_cyc(2);
    chk("dn_loaded", 32'(mcnt), 5);
    step_log.delete();
    wr("w_ctrl_dn", 5'h00, 32'hD, 4'hF);
    wait_cyc(15);
    chk("dn_steps", step_log.size(), 5);
    chk("dn_cnt", 32'(mcnt), 0);
    chk("dn_irq", {31'd0, irq}, 1);
    chk("dn_up", {31'd0, up}, 0);
    rd("dn_status", 5'h14, 32'h1);
    rd("dn_ctrl", 5'h00, 32'hC);
    wr("w_w1c", 5'h14, 32'h1, 4'hF);
    wait_cyc(2);
    chk("w1c_irq", {31'd0, irq}, 0);
    rd("w1c_status", 5'h14, 32'h0);

    // One-shot up from 6 to LIMIT 8
    wr("w_limit", 5'h08, 32'd8, 4'hF);
    wr("w_load6", 5'h0C, 32'd6, 4'hF);
    wait_cyc(2);
    step_log.delete();
    wr("w_ctrl_up", 5'h00, 32'h7, 4'hF);
    wait_cyc(10);
    chk("up_steps", step_log.size(), 2);
    chk("up_cnt", 32'(mcnt), 8);
    chk("up_irq", {31'd0, irq}, 0);
    rd("up_status", 5'h14, 32'h1);
    rd("up_ctrl", 5'h00, 32'h6);
    rd("r_limit", 5'h08, 32'd8);
    wr("w_w1c2", 5'h14, 32'h1, 4'hF);

    // Load landing on a prescaler wrap
    wr("w_presc3", 5'h04, 32'd3, 4'hF);
    wr("w_ctrl_fr", 5'h00, 32'h3, 4'hF);
    step_log.delete();
    load_log.delete();
    n = 0;
    while (step_log.size() == 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("wrap_seen", {31'd0, step_log.size() > 0}, 1);
    repeat (2) @(posedge clk);
    wr("w_load_wrap", 5'h0C, 32'h0000_0100, 4'hF);
    wait_cyc(8);
    chk("ld_n", load_log.size(), 1);
    chk("ld_nostep", {31'd0, step_at_load}, 0);
    chk("ld_val", 32'(load_val), 32'h100);
    L = (load_log.size() > 0) ? load_log[0] : 0;
    prev = -1000;
    nxt  = -1000;
    foreach (step_log[i]) begin
      if (step_log[i] < L) prev = step_log[i];
      else if (step_log[i] > L && nxt < 0) nxt = step_log[i];
    end
    chk("ld_prev_gap", L - prev, 4);
    chk("ld_next_gap", nxt - L, 4);
    wr("w_stop2", 5'h00, 32'h0, 4'hF);

    // Byte lanes, reserved/unmapped addresses
    wr("w_ctrl_b1", 5'h00, 32'hFFFF_FFFF, 4'b0010);
    step_log.delete();
    wait_cyc(8);
    chk("b1_nosteps", step_log.size(), 0);
    rd("b1_ctrl", 5'h00, 32'h0);
    wr("w_presc_b1", 5'h04, 32'h0000_AB12, 4'b0010);
    rd("b1_presc", 5'h04, 32'h0000_AB03);
    rd("r_load", 5'h0C, 32'h0);
    wr("w_rsvd", 5'h18, 32'hFFFF_FFFF, 4'hF);
    rd("r_rsvd", 5'h18, 32'h0);
    bus("nomatch_rd", 1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h0, 1'b0);
    bus("nomatch_wr", 1'b1, 32'h3100_0000, 32'h1, 4'hF, 32'h0, 1'b0);
    rd("nomatch_ctrl", 5'h00, 32'h0);

    // Reset during ACK, strobe held
    wr("w_ctrl_rst", 5'h00, 32'h3, 4'hF);
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = BASE;
    begin
      exp_t e;
      e.tag = "rst_rd";
      e.val = 32'h3;
      exp_q.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.wbs_ack_o && n < 8);
    chk("rst_ack_seen", {31'd0, wb.wbs_ack_o}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ack_drop", {31'd0, wb.wbs_ack_o}, 0);
    @(negedge clk);
    chk("rst_ack_held", {31'd0, wb.wbs_ack_o}, 0);
    @(posedge clk); #1;
    bus_idle();
    rst_n = 1'b1;

    // Load write cancelled by a coincident reset
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = BASE | 32'h0C;
    wb.wbs_dat_i = 32'h0000_1234;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_noload", {31'd0, load}, 0);
    chk("rst_noack", {31'd0, wb.wbs_ack_o}, 0);
    @(posedge clk); #1;
    bus_idle();
    rst_n = 1'b1;
    wait_cyc(1);
    chk("post_lval", 32'(load_val), 0);
    chk("post_irq_step", {30'd0, irq, step}, 0);
    rd("post_ctrl", 5'h00, 32'h0);
    rd("post_presc", 5'h04, 32'h0);

    wait_cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
